// File: rtl/tri_raster_scan.sv
// tri_raster_scan: rasterises one triangle by walking its bounding box with add-only edge functions
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   tri_valid/tri_ready       triangle handshake; v0x..v2y sampled on acceptance
//   pix_valid/pix_ready       covered-pixel stream: pix_x, pix_y and edge values pix_w0..pix_w2
//   tri_done                  one-cycle pulse once the triangle has been fully processed
module tri_raster_scan #(
    parameter int CW = 16,
    parameter int EW = 2 * CW + 3,
    parameter bit TWO_SIDED = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tri_valid,
    output logic          tri_ready,
    input  logic [CW-1:0] v0x,
    input  logic [CW-1:0] v0y,
    input  logic [CW-1:0] v1x,
    input  logic [CW-1:0] v1y,
    input  logic [CW-1:0] v2x,
    input  logic [CW-1:0] v2y,
    output logic          pix_valid,
    input  logic          pix_ready,
    output logic [CW-1:0] pix_x,
    output logic [CW-1:0] pix_y,
    output logic [EW-1:0] pix_w0,
    output logic [EW-1:0] pix_w1,
    output logic [EW-1:0] pix_w2,
    output logic          tri_done
);
    localparam logic [2:0] IDLE = 3'd0, SETUP1 = 3'd1, SETUP2 = 3'd2, SCAN = 3'd3, DRAIN = 3'd4, DONE = 3'd5;

    logic [2:0] state;
    logic [CW-1:0] t0x, t0y, t1x, t1y, t2x, t2y;
    logic [CW-1:0] minx, maxx, miny, maxy, x, y;
    logic signed [EW-1:0] dx0, dx1, dx2, dy0, dy1, dy2;
    logic signed [EW-1:0] e0, e1, e2, s0, s1, s2;
    logic signed [EW-1:0] area, f0, f1, f2;
    logic neg, cov, free;

    function automatic logic signed [EW-1:0] dif(input logic [CW-1:0] a, input logic [CW-1:0] b);
        return $signed({{(EW-CW){1'b0}}, a}) - $signed({{(EW-CW){1'b0}}, b});
    endfunction

    function automatic logic [CW-1:0] mn3(input logic [CW-1:0] a, input logic [CW-1:0] b, input logic [CW-1:0] c);
        return a < b ? (a < c ? a : c) : (b < c ? b : c);
    endfunction

    function automatic logic [CW-1:0] mx3(input logic [CW-1:0] a, input logic [CW-1:0] b, input logic [CW-1:0] c);
        return a > b ? (a > c ? a : c) : (b > c ? b : c);
    endfunction

    // edge(a,b,p) rewritten as dY*(py-ay) + dX*(px-ax) using the steps latched in SETUP1
    assign area = dy2 * dif(t2y, t0y) + dx2 * dif(t2x, t0x);
    assign f0 = dy0 * dif(miny, t1y) + dx0 * dif(minx, t1x);
    assign f1 = dy1 * dif(miny, t2y) + dx1 * dif(minx, t2x);
    assign f2 = dy2 * dif(miny, t0y) + dx2 * dif(minx, t0x);

    // negative-area triangles cover the region where every edge value is <= 0
    assign cov = neg ? ((e0[EW-1] || e0 == '0) && (e1[EW-1] || e1 == '0) && (e2[EW-1] || e2 == '0))
                     : !(e0[EW-1] || e1[EW-1] || e2[EW-1]);
    assign free = !pix_valid || pix_ready;
    assign tri_ready = state == IDLE && !rst;
    assign tri_done = state == DONE;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            pix_valid <= 1'b0;
            pix_x <= '0;
            pix_y <= '0;
            pix_w0 <= '0;
            pix_w1 <= '0;
            pix_w2 <= '0;
        end else begin
            if (pix_valid && pix_ready) pix_valid <= 1'b0;
            case (state)
                IDLE: if (tri_valid && tri_ready) begin
                    t0x <= v0x; t0y <= v0y;
                    t1x <= v1x; t1y <= v1y;
                    t2x <= v2x; t2y <= v2y;
                    state <= SETUP1;
                end
                SETUP1: begin
                    minx <= mn3(t0x, t1x, t2x);
                    maxx <= mx3(t0x, t1x, t2x);
                    miny <= mn3(t0y, t1y, t2y);
                    maxy <= mx3(t0y, t1y, t2y);
                    dx0 <= dif(t1y, t2y); dy0 <= dif(t2x, t1x);
                    dx1 <= dif(t2y, t0y); dy1 <= dif(t0x, t2x);
                    dx2 <= dif(t0y, t1y); dy2 <= dif(t1x, t0x);
                    state <= SETUP2;
                end
                SETUP2: begin
                    e0 <= f0; e1 <= f1; e2 <= f2;
                    s0 <= f0; s1 <= f1; s2 <= f2;
                    x <= minx;
                    y <= miny;
                    neg <= area[EW-1];
                    state <= (area == '0 || (area[EW-1] && !TWO_SIDED)) ? DONE : SCAN;
                end
                SCAN: if (free) begin
                    if (cov) begin
                        pix_valid <= 1'b1;
                        pix_x <= x; pix_y <= y;
                        pix_w0 <= e0; pix_w1 <= e1; pix_w2 <= e2;
                    end
                    // bounds are compared before stepping so a box ending at 2^CW-1 never wraps
                    if (x != maxx) begin
                        x <= x + 1'b1;
                        e0 <= e0 + dx0; e1 <= e1 + dx1; e2 <= e2 + dx2;
                    end else if (y != maxy) begin
                        x <= minx;
                        y <= y + 1'b1;
                        s0 <= s0 + dy0; s1 <= s1 + dy1; s2 <= s2 + dy2;
                        e0 <= s0 + dy0; e1 <= s1 + dy1; e2 <= s2 + dy2;
                    end else state <= DRAIN;
                end
                DRAIN: if (free) state <= DONE;
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
